// File: rtl/eth_pkg.sv
// Shared Ethernet framing types and constants.
// Also provides the header byte selector.
package eth_pkg;

  typedef logic [7:0]  byte_t;
  typedef logic [47:0] mac_addr_t;

  localparam int unsigned ETH_HEADER_LEN  = 14;
  localparam int unsigned ETH_MIN_PAYLOAD = 46;
  localparam logic [15:0] ETHERTYPE_IPV4  = 16'h0800;

  // Header is {DST, SRC, ETHERTYPE}, transmitted MSB first; idx selects byte 0..13.
  function automatic byte_t hdr_byte(input mac_addr_t   dst,
                                     input mac_addr_t   src,
                                     input logic [15:0] etype,
                                     input logic [3:0]  idx);
    logic [111:0] hdr;
    hdr = {dst, src, etype} << (8 * idx);
    return hdr[111:104];
  endfunction

endpackage

// File: rtl/eth_framer_if.sv
// Payload-in / frame-out byte stream bundle for eth_framer.
// master = environment side, slave = framer side.
interface eth_framer_if;
  import eth_pkg::*;

  logic  in_valid;
  byte_t in_data;
  logic  in_eof;
  logic  in_err;
  logic  in_ready;

  logic  tx_valid;
  byte_t tx_data;
  logic  tx_eof;
  logic  tx_err;
  logic  tx_ready;

  modport master (
    output in_valid, in_data, in_eof, in_err, tx_ready,
    input  in_ready, tx_valid, tx_data, tx_eof, tx_err
  );

  modport slave (
    input  in_valid, in_data, in_eof, in_err, tx_ready,
    output in_ready, tx_valid, tx_data, tx_eof, tx_err
  );
endinterface

// File: rtl/eth_framer.sv
// Prepends a 14-byte Ethernet header to a payload stream and zero-pads
// short payloads to the 46-byte minimum; output is a registered byte stream.
module eth_framer
  import eth_pkg::*;
#(
  parameter logic [15:0] ETHERTYPE = ETHERTYPE_IPV4,
  parameter mac_addr_t   SRC_MAC   = 48'h02_00_00_00_00_01,
  parameter mac_addr_t   DST_MAC   = 48'hFF_FF_FF_FF_FF_FF
) (
  input  logic         clk,
  input  logic         rst,
  eth_framer_if.slave  bus
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_HEADER  = 2'd1;
  localparam logic [1:0] ST_PAYLOAD = 2'd2;
  localparam logic [1:0] ST_PAD     = 2'd3;

  localparam logic [3:0] HDR_LAST = 4'(ETH_HEADER_LEN - 1);
  localparam logic [5:0] PAY_MAX  = 6'(ETH_MIN_PAYLOAD);
  localparam logic [5:0] PAY_LAST = 6'(ETH_MIN_PAYLOAD - 1);

  logic [1:0] state;
  logic [3:0] hdr_cnt;
  logic [5:0] pay_cnt;
  logic [5:0] pay_next;
  logic       pay_full;
  logic       load;

  assign load         = !bus.tx_valid || bus.tx_ready;
  assign bus.in_ready = (state == ST_PAYLOAD) && load;

  // pay_full: the byte loaded now brings the payload count to the minimum.
  always_comb begin
    pay_next = (pay_cnt == PAY_MAX) ? pay_cnt : pay_cnt + 6'd1;
    pay_full = (pay_cnt >= PAY_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      hdr_cnt      <= '0;
      pay_cnt      <= '0;
      bus.tx_valid <= 1'b0;
      bus.tx_data  <= '0;
      bus.tx_eof   <= 1'b0;
      bus.tx_err   <= 1'b0;
    end else if (load) begin
      bus.tx_valid <= 1'b0;
      bus.tx_eof   <= 1'b0;
      bus.tx_err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            bus.tx_valid <= 1'b1;
            bus.tx_data  <= hdr_byte(DST_MAC, SRC_MAC, ETHERTYPE, 4'd0);
            hdr_cnt      <= 4'd1;
            state        <= ST_HEADER;
          end
        end
        ST_HEADER: begin
          bus.tx_valid <= 1'b1;
          bus.tx_data  <= hdr_byte(DST_MAC, SRC_MAC, ETHERTYPE, hdr_cnt);
          hdr_cnt      <= hdr_cnt + 4'd1;
          if (hdr_cnt == HDR_LAST) state <= ST_PAYLOAD;
        end
        ST_PAYLOAD: begin
          if (bus.in_valid) begin
            bus.tx_valid <= 1'b1;
            bus.tx_data  <= bus.in_data;
            pay_cnt      <= pay_next;
            if (bus.in_eof) begin
              if (bus.in_err || pay_full) begin
                bus.tx_eof <= 1'b1;
                bus.tx_err <= bus.in_err;
                state      <= ST_IDLE;
                hdr_cnt    <= '0;
                pay_cnt    <= '0;
              end else begin
                state <= ST_PAD;
              end
            end
          end
        end
        ST_PAD: begin
          bus.tx_valid <= 1'b1;
          bus.tx_data  <= '0;
          pay_cnt      <= pay_next;
          if (pay_full) begin
            bus.tx_eof <= 1'b1;
            state      <= ST_IDLE;
            hdr_cnt    <= '0;
            pay_cnt    <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_framer.sv
// Self-checking bench for eth_framer: directed vector table, random frames
// against a queue-based frame model, and a mid-frame reset sequence.
module tb_eth_framer;
  import eth_pkg::*;

  localparam logic [15:0] ET  = 16'h0800;
  localparam mac_addr_t   SRC = 48'h02_00_00_00_00_01;
  localparam mac_addr_t   DST = 48'hFF_FF_FF_FF_FF_FF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  eth_framer_if bus ();

  eth_framer #(.ETHERTYPE(ET), .SRC_MAC(SRC), .DST_MAC(DST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    byte_t d;
    logic  eof;
    logic  err;
  } beat_t;

  typedef struct {
    int n;
    int abort_at;
    bit rand_ready;
    int exp_len;
  } vec_t;

  beat_t cap[$];
  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  bit    got_eof = 0;
  bit    stall_prev = 0;
  beat_t stall_beat;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Capture accepted bytes and verify output stability across stalls.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", 32'(bus.tx_valid), 32'd1);
        check("stall_hold", 32'({bus.tx_data, bus.tx_eof, bus.tx_err}), 32'(stall_beat));
      end
      if (bus.tx_valid && bus.tx_ready) begin
        cap.push_back('{d: bus.tx_data, eof: bus.tx_eof, err: bus.tx_err});
        if (bus.tx_eof) got_eof = 1;
      end
      stall_prev = bus.tx_valid && !bus.tx_ready;
      stall_beat = '{d: bus.tx_data, eof: bus.tx_eof, err: bus.tx_err};
    end
  end

  // Reference frame: header, payload, zero pad to 60 bytes unless aborted.
  task automatic build_exp(input byte_t pay[$], input bit aborted);
    logic [47:0] d;
    logic [47:0] s;
    logic [15:0] e;
    beat_t b;
    d = DST;
    s = SRC;
    e = ET;
    exp_q.delete();
    for (int i = 0; i < 6; i++) exp_q.push_back('{d: d[8*(5-i) +: 8], eof: 1'b0, err: 1'b0});
    for (int i = 0; i < 6; i++) exp_q.push_back('{d: s[8*(5-i) +: 8], eof: 1'b0, err: 1'b0});
    exp_q.push_back('{d: e[15:8], eof: 1'b0, err: 1'b0});
    exp_q.push_back('{d: e[7:0], eof: 1'b0, err: 1'b0});
    foreach (pay[i]) exp_q.push_back('{d: pay[i], eof: 1'b0, err: 1'b0});
    if (!aborted)
      while (exp_q.size() < 60) exp_q.push_back('{d: 8'h00, eof: 1'b0, err: 1'b0});
    b = exp_q.pop_back();
    b.eof = 1'b1;
    b.err = aborted;
    exp_q.push_back(b);
  endtask

  task automatic run_frame(input string tag, input int n, input int abort_at,
                           input bit rand_ready, input bit inc_pat, input int exp_len);
    byte_t pay[$];
    int    eff_n, idx, waits, stalls, budget;
    bit    started, aborted;
    aborted = (abort_at >= 0) && (abort_at < n);
    eff_n   = aborted ? abort_at + 1 : n;
    for (int i = 0; i < eff_n; i++) pay.push_back(inc_pat ? byte_t'(i + 1) : byte_t'($urandom));
    build_exp(pay, aborted);
    cap.delete();
    got_eof = 0;
    idx = 0; waits = 0; stalls = 0; budget = 0; started = 0;
    while (idx < eff_n && budget < 5000) begin
      @(posedge clk); #1;
      bus.in_valid = 1'b1;
      bus.in_data  = pay[idx];
      bus.in_eof   = (idx == eff_n - 1);
      bus.in_err   = (idx == eff_n - 1) ? aborted : 1'($urandom_range(0, 1));
      bus.tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (bus.in_ready) begin
        idx++;
        started = 1;
      end else if (!started) waits++;
      else stalls++;
      budget++;
    end
    check({tag, "_accept_all"}, 32'(idx), 32'(eff_n));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_eof   = 1'b0;
    bus.in_err   = 1'b0;
    budget = 0;
    while (!got_eof && budget < 5000) begin
      bus.tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk); #1;
      budget++;
      if (!got_eof) begin
        @(posedge clk); #1;
      end
    end
    check({tag, "_eof_seen"}, 32'(got_eof), 32'd1);
    bus.tx_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_idle_after"}, 32'(bus.tx_valid), 32'd0);
    if (exp_len > 0) check({tag, "_len_const"}, 32'(cap.size()), 32'(exp_len));
    if (!rand_ready) begin
      check({tag, "_hdr_latency"}, 32'(waits), 32'd14);
      check({tag, "_no_in_stall"}, 32'(stalls), 32'd0);
    end
    check({tag, "_len_model"}, 32'(cap.size()), 32'(exp_q.size()));
    for (int i = 0; i < cap.size() && i < exp_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), 32'(cap[i]), 32'(exp_q[i]));
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    int   eofs;
    vecs[0] = '{n: 10,  abort_at: -1, rand_ready: 1'b0, exp_len: 60};
    vecs[1] = '{n: 46,  abort_at: -1, rand_ready: 1'b0, exp_len: 60};
    vecs[2] = '{n: 100, abort_at: -1, rand_ready: 1'b0, exp_len: 114};
    vecs[3] = '{n: 10,  abort_at: -1, rand_ready: 1'b1, exp_len: 60};
    vecs[4] = '{n: 10,  abort_at: 5,  rand_ready: 1'b0, exp_len: 20};
    vecs[5] = '{n: 45,  abort_at: -1, rand_ready: 1'b0, exp_len: 60};
    vecs[6] = '{n: 47,  abort_at: -1, rand_ready: 1'b1, exp_len: 61};
    vecs[7] = '{n: 1,   abort_at: -1, rand_ready: 1'b0, exp_len: 60};

    bus.in_valid = 1'b1;
    bus.in_data  = 8'hA5;
    bus.in_eof   = 1'b0;
    bus.in_err   = 1'b0;
    bus.tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("rst_tx_data",  32'(bus.tx_data),  32'd0);
    check("rst_tx_eof",   32'(bus.tx_eof),   32'd0);
    check("rst_tx_err",   32'(bus.tx_err),   32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i])
      run_frame($sformatf("vec%0d", i), vecs[i].n, vecs[i].abort_at,
                vecs[i].rand_ready, 1'b1, vecs[i].exp_len);

    for (int f = 0; f < 20; f++) begin
      int n, ab;
      n  = $urandom_range(1, 80);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
      run_frame($sformatf("rnd%0d", f), n, ab, 1'($urandom_range(0, 1)), 1'b0, 0);
    end

    // Reset while header byte 8 is on the output.
    cap.delete();
    got_eof = 0;
    bus.in_valid = 1'b1;
    bus.in_eof   = 1'b0;
    bus.tx_ready = 1'b1;
    repeat (9) @(posedge clk);
    #1;
    check("pre_rst_valid", 32'(bus.tx_valid), 32'd1);
    check("pre_rst_byte8", 32'(bus.tx_data),  32'h00);
    rst = 1'b1;
    #1;
    check("mid_rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("mid_rst_tx_data",  32'(bus.tx_data),  32'd0);
    check("mid_rst_tx_eof",   32'(bus.tx_eof),   32'd0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
    eofs = 0;
    foreach (cap[i]) if (cap[i].eof) eofs++;
    check("mid_rst_no_eof", 32'(eofs), 32'd0);
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    run_frame("post_rst", 10, -1, 1'b0, 1'b1, 60);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/eth_framer.md
ETH_FRAMER -- requirements
Module: eth_framer

Interface
REQ-001 SHALL have parameter ETHERTYPE, default 16'h0800, EtherType inserted in header bytes 12-13.
REQ-002 SHALL have parameter SRC_MAC, default 48'h02_00_00_00_00_01, source address in header bytes 6-11.
REQ-003 SHALL have parameter DST_MAC, default 48'hFF_FF_FF_FF_FF_FF, destination address in header bytes 0-5.
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 rst  in  1  reset; asynchronous, active-high.
REQ-006 in_valid  in  1  upstream payload byte valid.
REQ-007 in_data  in  8 (byte_t)  upstream payload byte.
REQ-008 in_eof  in  1  current byte is last payload byte.
REQ-009 in_err  in  1  frame abort; qualified only with in_eof.
REQ-010 in_ready  out  1  payload byte accepted when in_valid && in_ready.
REQ-011 tx_valid  out  1  registered output byte valid towards MAC TX FIFO.
REQ-012 tx_data  out  8 (byte_t)  output frame byte.
REQ-013 tx_eof  out  1  last byte of frame.
REQ-014 tx_err  out  1  frame aborted; valid only with tx_eof.
REQ-015 tx_ready  in  1  downstream accepts byte when tx_valid && tx_ready.

Function
REQ-016 SHALL implement FSM states IDLE, HEADER, PAYLOAD, PAD.
REQ-017 Output register "load" condition SHALL be !tx_valid || tx_ready; tx_data/tx_eof/tx_err SHALL be held stable while tx_valid && !tx_ready.
REQ-018 On load with nothing to send, tx_valid SHALL clear next cycle.
REQ-019 IDLE: in_ready=0; when in_valid=1 and load, SHALL load header byte 0, set hdr_cnt=1, go HEADER (no payload byte consumed).
REQ-020 HEADER: each load SHALL output header byte hdr_cnt (DST_MAC MSB first, SRC_MAC MSB first, ETHERTYPE MSB then LSB), increment hdr_cnt; after loading byte 13 SHALL go PAYLOAD.
REQ-021 PAYLOAD: in_ready SHALL equal load (combinational); accepted byte SHALL be loaded into tx_data; pay_cnt (6-bit) SHALL increment, saturating at 46.
REQ-022 Accepted byte with in_eof=1, in_err=0, pay_cnt+1 >= 46: tx_eof=1 on that byte, go IDLE.
REQ-023 Accepted byte with in_eof=1, in_err=0, pay_cnt+1 < 46: tx_eof=0, go PAD.
REQ-024 PAD: in_ready=0; each load SHALL output 8'h00 and increment pay_cnt; the byte bringing pay_cnt to 46 SHALL carry tx_eof=1, then go IDLE.
REQ-025 Accepted byte with in_eof=1, in_err=1: byte output with tx_eof=1, tx_err=1, no padding, go IDLE.
REQ-026 in_err without in_eof SHALL be ignored.
REQ-027 Total frame length SHALL be max(14+N, 60) for N payload bytes (no FCS; MAC appends).
REQ-028 Latency, tx_ready held high: header byte 0 on tx one cycle after in_valid sampled in IDLE; payload byte k on tx at cycle 15+k.
REQ-029 hdr_cnt and pay_cnt SHALL clear on return to IDLE.
REQ-030 Back-to-back frames: IDLE SHALL be entered for at least one cycle between frames.

Reset
REQ-031 While rst=1: state=IDLE, tx_valid=0, tx_data=8'h00, tx_eof=0, tx_err=0, in_ready=0, counters=0.
REQ-032 Reset mid-frame SHALL abandon the frame immediately; no tx_eof emitted for it.

Structure
REQ-033 byte_t, mac_addr_t, ETH_HEADER_LEN=14, ETH_MIN_PAYLOAD=46, ETHERTYPE_IPV4 SHALL live in eth_pkg.
REQ-034 Single module; no sub-module.

Verification
REQ-035 10-byte payload 0x01..0x0A -> 60 bytes; bytes 0-5 FF, 12-13 08 00, 14-23 payload, 24-59 00; tx_eof only on byte 59.
REQ-036 46-byte payload -> 60 bytes, no pad, tx_eof on byte 59 (payload byte 45).
REQ-037 100-byte payload -> 114 bytes, tx_eof on byte 113, in_ready never drops with tx_ready=1.
REQ-038 tx_ready random 50% toggling over 10-byte frame -> same 60-byte sequence, tx_data stable during stalls.
REQ-039 in_eof+in_err on payload byte 5 -> 20 bytes total, tx_eof=tx_err=1 on byte 19, then IDLE.
REQ-040 rst pulsed at header byte 8 -> outputs zero same cycle; next frame starts cleanly with DST byte 0.
